systolic_tile: RTL
==================

# systolic_tile

Parametrised DIM×DIM output-stationary systolic matrix-multiply tile: the next-generation compute core of the TPU. It accepts streamed A-column/B-row vectors, skews them internally, and accumulates C = A·B in a PE grid. It supports stall bubbles, tile-K chaining (accumulate mode), and saturating/ReLU output conversion. Results are drained one C row per beat over a valid/ready interface; the block sits between the buffer-fetch controller and the P-buffer writer.

## Interface
- DIM, 8, array rows = columns = vector lanes
- DATA_W, 8, signed operand width
- ACC_W, 32, signed accumulator width
- OUT_W, 16, signed output lane width (OUT_W ≤ ACC_W)
- clk_i  in  1  clock; one clock domain
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid && ready
- in_last_i  in  1  final beat of the tile
- in_accum_i  in  1  sampled on first beat: 1 = keep prior accumulators
- in_relu_i  in  1  sampled on first beat: 1 = clamp negative outputs to 0
- a_word_i  in  DIM*DATA_W  column k of A; lane r = A[r][k]
- b_word_i  in  DIM*DATA_W  row k of B; lane c = B[k][c]
- p_valid_o  out  1  result row valid
- p_ready_i  in  1  result row consumed
- p_data_o  out  DIM*OUT_W  row r of C; lane c = C[r][c]
- p_row_o  out  $clog2(DIM)  current row index
- p_last_o  out  1  high with row DIM-1
- busy_o  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, STREAM, FLUSH, DRAIN. Reset → IDLE.
- IDLE: in_ready_o=1. The first accepted beat is the tile's first beat; it latches accum/relu and moves to STREAM, or to FLUSH if in_last_i=1.
- STREAM: in_ready_o=1. When in_valid_i=0, zero lanes are injected (bubble); a zero product leaves accumulators unchanged. An accepted beat with in_last_i=1 moves to FLUSH.
- FLUSH: in_ready_o=0, zeros injected, counter runs 2*DIM-1 cycles, then → DRAIN.
- DRAIN: in_ready_o=0. Row counter runs 0..DIM-1 and advances on p_valid_o && p_ready_i. The handshake on row DIM-1 → IDLE.
- Skew: lane r of A is delayed r cycles, lane c of B is delayed c cycles. A propagates right and B down one register per PE, so PE(r,c) consumes beat j at j+r+c cycles after acceptance.
- First-beat flag travels with the skewed data. When a PE sees it with accum=0, the PE loads the product; otherwise acc += product.
- Products are full 2*DATA_W wide and sign-extended. Accumulators wrap modulo 2^ACC_W.
- Output lane conversion: (relu && acc<0) → 0. Otherwise acc is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Accumulators hold through DRAIN and IDLE; they are never cleared except by a first beat with accum=0, or by reset.

## Timing
- Reset values: in_ready_o=1, p_valid_o=0, p_data_o=0, p_row_o=0, p_last_o=0, busy_o=0. All accumulators, skew registers and counters are 0.
- If the last beat is accepted in cycle t, FLUSH covers t+1..t+2*DIM-1 and p_valid_o first rises in cycle t+2*DIM.
- p_data_o is registered and stable while p_valid_o && !p_ready_i. p_valid_o stays high continuously across rows when p_ready_i=1, giving 1 row/cycle.
- in_ready_o returns to 1 the cycle after the final row handshake.
- A single-beat tile (first = last) is legal.
- Reset asserted mid-operation → immediate IDLE. Results are discarded, and no partial p_valid_o remains after release.

## Structure
- def.v gains FSM state encodings and default parameter macros.
- Natural sub-module: mac_pe, which holds A/B pass-through registers, the first-flag register, and the accumulator with the load/accumulate select.
- systolic_tile contains the generate loops for the skew shift-registers, the DIM×DIM mac_pe grid, the FSM/counters, and the row mux plus saturation.

## Test plan
- Identity: DIM=4, A=I, B rows {1..4},{5..8},{9..12},{13..16}, K=4. Drained rows must equal B. p_valid_o first rises 8 cycles after the last beat. p_last_o is asserted only on row 3.
- Bubbles: repeat the identity test with in_valid_i low on alternate cycles. Results must be identical, and the FLUSH length must be unchanged.
- Chaining: tile 1 uses A=B=all 1, K=3, and every lane must read 3. Tile 2 uses in_accum_i=1, K=2, and every lane must read 5. Tile 3 uses accum=0, K=1, and every lane must read 1.
- Saturation/ReLU (OUT_W=16):
  - A=127, B=127, K=4 → 32767.
  - A=-128, B=127, K=4 → -32768.
  - The same negative case with relu=1 → 0.
- Backpressure: hold p_ready_i low for 3 cycles on row 1. p_data_o and p_row_o must stay stable, rows must arrive in order 0..3, and in_ready_o must stay 0 until after row 3.
- Reset: assert rst_ni mid-DRAIN. Outputs must go to their reset values at once. A new tile afterwards must produce correct results with no stale accumulation.

Source files
------------

// File: rtl/systolic_tile_pkg.sv
// Shared types and default sizes for the systolic matrix-multiply tile.
// Imported by the PE and the tile top.
package systolic_tile_pkg;

   localparam int DEF_DIM    = 8;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 32;
   localparam int DEF_OUT_W  = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_DRAIN
   } state_e;

endpackage

// File: rtl/systolic_tile_mac.sv
// Output-stationary MAC processing element: A/B/flag pass-through
// registers and a load-or-accumulate accumulator.
module mac_pe
   import systolic_tile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              load_i,
   output logic [DATA_W-1:0] a_o,
   output logic [DATA_W-1:0] b_o,
   output logic              load_o,
   output logic [ACC_W-1:0]  acc_o
);

   logic signed [2*DATA_W-1:0] w_prod;
   logic        [ACC_W-1:0]    w_ext;
   logic        [DATA_W-1:0]   r_a;
   logic        [DATA_W-1:0]   r_b;
   logic                       r_load;
   logic        [ACC_W-1:0]    r_acc;

   assign w_prod = $signed(a_i) * $signed(b_i);
   assign w_ext  = ACC_W'(w_prod);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_a    <= '0;
         r_b    <= '0;
         r_load <= 1'b0;
         r_acc  <= '0;
      end else begin
         r_a    <= a_i;
         r_b    <= b_i;
         r_load <= load_i;
         r_acc  <= load_i ? w_ext : r_acc + w_ext;
      end
   end

   assign a_o    = r_a;
   assign b_o    = r_b;
   assign load_o = r_load;
   assign acc_o  = r_acc;

endmodule

// File: rtl/systolic_tile.sv
// DIMxDIM output-stationary systolic tile: input skew, PE grid,
// stream/flush/drain control and saturating/ReLU row output.
module systolic_tile
   import systolic_tile_pkg::*;
#(
   parameter int DIM    = DEF_DIM,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic                   in_last_i,
   input  logic                   in_accum_i,
   input  logic                   in_relu_i,
   input  logic [DIM*DATA_W-1:0]  a_word_i,
   input  logic [DIM*DATA_W-1:0]  b_word_i,
   output logic                   p_valid_o,
   input  logic                   p_ready_i,
   output logic [DIM*OUT_W-1:0]   p_data_o,
   output logic [$clog2(DIM)-1:0] p_row_o,
   output logic                   p_last_o,
   output logic                   busy_o
);

   localparam int ROW_W = $clog2(DIM);
   localparam int CNT_W = $clog2(2*DIM);
   localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(2*DIM-2);
   localparam logic [ROW_W-1:0] ROW_END   = ROW_W'(DIM-1);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   state_e                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [ROW_W-1:0]       r_row;
   logic                   r_relu;
   logic                   r_in_ready;
   logic                   r_p_valid;
   logic                   r_p_last;
   logic [DIM*OUT_W-1:0]   r_p_data;

   logic                   w_accept;
   logic                   w_load;
   logic [DATA_W-1:0]      w_a_in [DIM];
   logic [DATA_W-1:0]      w_b_in [DIM];
   logic [DATA_W-1:0]      w_a_sk [DIM];
   logic [DATA_W-1:0]      w_b_sk [DIM];
   logic                   w_ld_sk [DIM];
   logic [DATA_W-1:0]      w_a [DIM][DIM+1];
   logic [DATA_W-1:0]      w_b [DIM+1][DIM];
   logic                   w_ld [DIM][DIM+1];
   logic [ACC_W-1:0]       w_acc [DIM][DIM];
   logic [ROW_W-1:0]       w_nxt_row;
   logic [DIM*OUT_W-1:0]   w_nxt_data;

   assign w_accept = in_valid_i && r_in_ready;
   assign w_load   = w_accept && (r_state == S_IDLE) && !in_accum_i;

   // Unaccepted cycles inject zero lanes so accumulators hold.
   for (genvar r = 0; r < DIM; r++) begin : g_skew
      assign w_a_in[r] = w_accept ? a_word_i[r*DATA_W +: DATA_W] : '0;
      assign w_b_in[r] = w_accept ? b_word_i[r*DATA_W +: DATA_W] : '0;
      if (r == 0) begin : g_d0
         assign w_a_sk[r]  = w_a_in[r];
         assign w_b_sk[r]  = w_b_in[r];
         assign w_ld_sk[r] = w_load;
      end else begin : g_dn
         logic [DATA_W-1:0] r_a_sh  [r];
         logic [DATA_W-1:0] r_b_sh  [r];
         logic              r_ld_sh [r];
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int i = 0; i < r; i++) begin
                  r_a_sh[i]  <= '0;
                  r_b_sh[i]  <= '0;
                  r_ld_sh[i] <= 1'b0;
               end
            end else begin
               r_a_sh[0]  <= w_a_in[r];
               r_b_sh[0]  <= w_b_in[r];
               r_ld_sh[0] <= w_load;
               for (int i = 1; i < r; i++) begin
                  r_a_sh[i]  <= r_a_sh[i-1];
                  r_b_sh[i]  <= r_b_sh[i-1];
                  r_ld_sh[i] <= r_ld_sh[i-1];
               end
            end
         end
         assign w_a_sk[r]  = r_a_sh[r-1];
         assign w_b_sk[r]  = r_b_sh[r-1];
         assign w_ld_sk[r] = r_ld_sh[r-1];
      end
      assign w_a[r][0]  = w_a_sk[r];
      assign w_ld[r][0] = w_ld_sk[r];
      assign w_b[0][r]  = w_b_sk[r];
   end

   for (genvar r = 0; r < DIM; r++) begin : g_row
      for (genvar c = 0; c < DIM; c++) begin : g_col
         mac_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .a_i    (w_a[r][c]),
            .b_i    (w_b[r][c]),
            .load_i (w_ld[r][c]),
            .a_o    (w_a[r][c+1]),
            .b_o    (w_b[r+1][c]),
            .load_o (w_ld[r][c+1]),
            .acc_o  (w_acc[r][c])
         );
      end
   end

   function automatic logic [OUT_W-1:0] f_conv(
      input logic [ACC_W-1:0] acc,
      input logic             relu
   );
      logic signed [ACC_W-1:0] s;
      s = $signed(acc);
      if (relu && s < 0) return '0;
      if (s > SAT_MAX)   return SAT_MAX[OUT_W-1:0];
      if (s < SAT_MIN)   return SAT_MIN[OUT_W-1:0];
      return acc[OUT_W-1:0];
   endfunction

   always_comb begin
      w_nxt_row  = (r_state == S_DRAIN) ? r_row + 1'b1 : '0;
      w_nxt_data = '0;
      for (int c = 0; c < DIM; c++)
         w_nxt_data[c*OUT_W +: OUT_W] = f_conv(w_acc[w_nxt_row][c], r_relu);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_row      <= '0;
         r_relu     <= 1'b0;
         r_in_ready <= 1'b1;
         r_p_valid  <= 1'b0;
         r_p_last   <= 1'b0;
         r_p_data   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: if (w_accept) begin
               r_relu <= in_relu_i;
               r_cnt  <= '0;
               if (in_last_i) begin
                  r_state    <= S_FLUSH;
                  r_in_ready <= 1'b0;
               end else begin
                  r_state <= S_STREAM;
               end
            end
            S_STREAM: if (w_accept && in_last_i) begin
               r_state    <= S_FLUSH;
               r_in_ready <= 1'b0;
               r_cnt      <= '0;
            end
            S_FLUSH: if (r_cnt == FLUSH_END) begin
               r_state   <= S_DRAIN;
               r_row     <= '0;
               r_p_valid <= 1'b1;
               r_p_data  <= w_nxt_data;
               r_p_last  <= (ROW_END == '0);
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            S_DRAIN: if (r_p_valid && p_ready_i) begin
               if (r_row == ROW_END) begin
                  r_state    <= S_IDLE;
                  r_p_valid  <= 1'b0;
                  r_p_last   <= 1'b0;
                  r_row      <= '0;
                  r_in_ready <= 1'b1;
               end else begin
                  r_row    <= w_nxt_row;
                  r_p_data <= w_nxt_data;
                  r_p_last <= (w_nxt_row == ROW_END);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o = r_in_ready;
   assign p_valid_o  = r_p_valid;
   assign p_data_o   = r_p_data;
   assign p_row_o    = r_row;
   assign p_last_o   = r_p_last;
   assign busy_o     = (r_state != S_IDLE);

endmodule
